vc_circular_buffer: RTL and testbench
=====================================

# vc_circular_buffer

Multi-channel successor to the single-queue router input buffer: NUM_VC independent circular FIFOs of BUFFER_SIZE flits each, sharing one write port and one read port selected by virtual-channel index. It sits at each router input port, between link receive and route/VC allocation. Beyond plain queueing, it provides per-VC occupancy counts, a registered credit-return pulse toward the upstream router, and sticky overflow/underflow error flags.

## Interface
- NUM_VC, 2, number of virtual channels (≥1)
- BUFFER_SIZE, 8, flits per VC (≥2, need not be a power of two)
- FLIT_SIZE, 8, flit width in bits
- Derived: PTR_W = $clog2(BUFFER_SIZE); CNT_W = $clog2(BUFFER_SIZE+1); VC_W = max(1, $clog2(NUM_VC))
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- data_i  input  FLIT_SIZE  flit to write
- write_i  input  1  write request
- write_vc_i  input  VC_W  target VC of write
- read_i  input  1  read (pop) request
- read_vc_i  input  VC_W  VC to read; also selects data_o
- data_o  output  FLIT_SIZE  head flit of VC read_vc_i (first-word fall-through)
- is_full_o  output  NUM_VC  bit v = VC v holds BUFFER_SIZE flits
- is_empty_o  output  NUM_VC  bit v = VC v holds 0 flits
- count_o  output  NUM_VC*CNT_W  occupancy of VC v at bits [v*CNT_W +: CNT_W]
- credit_o  output  1  one-cycle pulse per accepted read
- credit_vc_o  output  VC_W  VC the credit belongs to (valid when credit_o=1)
- overflow_o  output  1  sticky: a write was rejected
- underflow_o  output  1  sticky: a read was rejected

## Operation
- Per VC state: read_ptr, write_ptr (PTR_W), count (CNT_W). Storage: NUM_VC×BUFFER_SIZE flits, not reset.
- Pointer increment wraps to 0 when ptr == BUFFER_SIZE-1.
- is_full_o[v] = (count[v] == BUFFER_SIZE), is_empty_o[v] = (count[v] == 0); decoded from registered state only.
- VC index valid iff < NUM_VC; an invalid index makes that request rejected.
- Read accepted (rd_acc): read_i & valid(read_vc_i) & ~is_empty_o[read_vc_i].
- Write accepted (wr_acc): write_i & valid(write_vc_i) & (~is_full_o[write_vc_i] | (rd_acc & read_vc_i == write_vc_i)).
- On wr_acc: mem[write_vc_i][write_ptr] <= data_i; write_ptr advances.
- On rd_acc: read_ptr advances.
- Count update per VC: +1 write only, −1 read only, unchanged when both hit the same VC or neither.
- Different VCs read and written in the same cycle proceed independently.
- Same-VC read+write while that VC is empty: write accepted, read rejected (no bypass); count becomes 1, underflow_o set.
- Same-VC read+write while full: both accepted, count stays BUFFER_SIZE, no overflow.
- Rejected write (write_i & ~wr_acc) sets overflow_o; rejected read (read_i & ~rd_acc) sets underflow_o. Both are cleared only by rst.
- data_o = mem[read_vc_i][read_ptr[read_vc_i]], combinational in read_vc_i. Its value is don't-care when that VC is empty or read_vc_i is invalid.

## Timing
- Reset values (after any rst edge): all pointers and counts 0; is_empty_o all 1; is_full_o all 0; count_o 0; credit_o 0; credit_vc_o 0; overflow_o 0; underflow_o 0.
- rst asserted mid-operation: contents are discarded at that edge, and a credit pulse due on the next cycle is suppressed. rst has priority over all requests.
- Write latency: a flit written at edge N appears on data_o (if at head) and in count_o/flags from edge N onward. Data cannot be read in the same cycle it is written.
- Read: data_o is valid in the same cycle read_i is asserted; the pop takes effect at the edge.
- Credit: rd_acc at edge N ⇒ credit_o=1 and credit_vc_o=read VC for exactly the cycle after edge N. Back-to-back reads give a continuous credit_o.
- No combinational path from write_i/read_i to any flag, count or credit output.

## Test plan
- Reset, then idle: is_empty_o=2'b11, is_full_o=0, count_o=0, credit_o=0, error flags 0.
- Write 0x11..0x18 to VC0 (8 cycles), 9th write 0x19 → is_full_o[0]=1, count0=8, overflow_o=1. Then 8 reads → data 0x11..0x18 in order, 8 credit pulses with credit_vc_o=0, is_empty_o[0]=1.
- Wrap-around with BUFFER_SIZE=5: write 5, read 3, write 3 → reads return correct FIFO order; count goes 5→2→5.
- Same cycle: write VC1 = 0xAA and read VC0 (holding 0x55) → data_o=0x55, count0 −1, count1 +1, credit_vc_o=0 next cycle.
- VC0 full, simultaneous read+write VC0 → count stays 8, overflow_o stays 0. VC1 empty, read+write VC1 → count1=1, underflow_o=1, no credit.
- rst asserted the cycle after a read with VC0 holding 3 flits → credit_o=0 next cycle, all counts 0, flags at reset values.

Source files
------------

// File: rtl/vc_circular_buffer.sv
// Multi-VC router input buffer: NUM_VC circular FIFOs behind one shared write port
// and one shared read port, with occupancy, credit-return pulse and sticky error flags.
module vc_circular_buffer #(
  parameter  int NUM_VC      = 2,
  parameter  int BUFFER_SIZE = 8,
  parameter  int FLIT_SIZE   = 8,
  localparam int PTR_W       = $clog2(BUFFER_SIZE),
  localparam int CNT_W       = $clog2(BUFFER_SIZE + 1),
  localparam int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_SIZE-1:0]    data_i,
  input  logic                    write_i,
  input  logic [VC_W-1:0]         write_vc_i,
  input  logic                    read_i,
  input  logic [VC_W-1:0]         read_vc_i,
  output logic [FLIT_SIZE-1:0]    data_o,
  output logic [NUM_VC-1:0]       is_full_o,
  output logic [NUM_VC-1:0]       is_empty_o,
  output logic [NUM_VC*CNT_W-1:0] count_o,
  output logic                    credit_o,
  output logic [VC_W-1:0]         credit_vc_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam logic [VC_W:0]    LP_NUM_VC   = (VC_W+1)'(NUM_VC);
  localparam logic [PTR_W-1:0] LP_PTR_LAST = PTR_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0] LP_CNT_FULL = CNT_W'(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] r_mem    [NUM_VC][BUFFER_SIZE];
  logic [PTR_W-1:0]     r_rd_ptr [NUM_VC];
  logic [PTR_W-1:0]     r_wr_ptr [NUM_VC];
  logic [CNT_W-1:0]     r_cnt    [NUM_VC];
  logic                 r_credit;
  logic [VC_W-1:0]      r_credit_vc;
  logic                 r_overflow;
  logic                 r_underflow;

  logic                 w_rd_vc_ok;
  logic                 w_wr_vc_ok;
  logic [VC_W-1:0]      w_rd_idx;
  logic [VC_W-1:0]      w_wr_idx;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic [NUM_VC-1:0]    w_full;
  logic [NUM_VC-1:0]    w_empty;
  logic [NUM_VC-1:0]    w_rd_hit;
  logic [NUM_VC-1:0]    w_wr_hit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LP_PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Out-of-range VC indices are folded to 0 so array selects stay in bounds;
  // the *_vc_ok qualifiers keep such requests from being accepted.
  assign w_rd_vc_ok = ({1'b0, read_vc_i} < LP_NUM_VC);
  assign w_wr_vc_ok = ({1'b0, write_vc_i} < LP_NUM_VC);
  assign w_rd_idx   = w_rd_vc_ok ? read_vc_i : '0;
  assign w_wr_idx   = w_wr_vc_ok ? write_vc_i : '0;

  always_comb begin
    w_full  = '0;
    w_empty = '0;
    count_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_full[v]                    = (r_cnt[v] == LP_CNT_FULL);
      w_empty[v]                   = (r_cnt[v] == '0);
      count_o[v*CNT_W +: CNT_W]    = r_cnt[v];
    end
  end

  // A full VC may still take a write when the same VC is popped in this cycle.
  assign w_rd_acc = read_i & w_rd_vc_ok & ~w_empty[w_rd_idx];
  assign w_wr_acc = write_i & w_wr_vc_ok &
                    (~w_full[w_wr_idx] | (w_rd_acc & (read_vc_i == write_vc_i)));

  always_comb begin
    w_rd_hit = '0;
    w_wr_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_rd_hit[v] = w_rd_acc & (w_rd_idx == VC_W'(v));
      w_wr_hit[v] = w_wr_acc & (w_wr_idx == VC_W'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
        r_cnt[v]    <= '0;
      end
      r_credit    <= 1'b0;
      r_credit_vc <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_wr_hit[v]) r_wr_ptr[v] <= next_ptr(r_wr_ptr[v]);
        if (w_rd_hit[v]) r_rd_ptr[v] <= next_ptr(r_rd_ptr[v]);
        if (w_wr_hit[v] && !w_rd_hit[v])      r_cnt[v] <= r_cnt[v] + CNT_W'(1);
        else if (w_rd_hit[v] && !w_wr_hit[v]) r_cnt[v] <= r_cnt[v] - CNT_W'(1);
      end
      r_credit <= w_rd_acc;
      if (w_rd_acc)             r_credit_vc <= read_vc_i;
      if (write_i && !w_wr_acc) r_overflow  <= 1'b1;
      if (read_i && !w_rd_acc)  r_underflow <= 1'b1;
    end
  end

  // Flit storage carries no reset; pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) r_mem[w_wr_idx][r_wr_ptr[w_wr_idx]] <= data_i;
  end

  assign data_o      = r_mem[w_rd_idx][r_rd_ptr[w_rd_idx]];
  assign is_full_o   = w_full;
  assign is_empty_o  = w_empty;
  assign credit_o    = r_credit;
  assign credit_vc_o = r_credit_vc;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule

// File: tb/tb_vc_circular_buffer.sv
// Bench for vc_circular_buffer: a 2x8 instance and a 3x5 instance (non-power-of-two
// depth, one unused VC index), each compared against a queue-based reference model.
module tb_vc_circular_buffer;

  localparam int A_VC = 2, A_BS = 8, A_CW = 4, A_VW = 1;
  localparam int B_VC = 3, B_BS = 5, B_CW = 3, B_VW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A signals
  logic [7:0]           data_a, dout_a;
  logic                 write_a, read_a;
  logic [A_VW-1:0]      wvc_a, rvc_a, cvc_a;
  logic [A_VC-1:0]      full_a, empty_a;
  logic [A_VC*A_CW-1:0] count_a;
  logic                 credit_a, ovf_a, udf_a;

  // instance B signals
  logic [7:0]           data_b, dout_b;
  logic                 write_b, read_b;
  logic [B_VW-1:0]      wvc_b, rvc_b, cvc_b;
  logic [B_VC-1:0]      full_b, empty_b;
  logic [B_VC*B_CW-1:0] count_b;
  logic                 credit_b, ovf_b, udf_b;

  vc_circular_buffer #(.NUM_VC(A_VC), .BUFFER_SIZE(A_BS), .FLIT_SIZE(8)) u_dut_a (
    .clk(clk), .rst(rst), .data_i(data_a), .write_i(write_a), .write_vc_i(wvc_a),
    .read_i(read_a), .read_vc_i(rvc_a), .data_o(dout_a), .is_full_o(full_a),
    .is_empty_o(empty_a), .count_o(count_a), .credit_o(credit_a), .credit_vc_o(cvc_a),
    .overflow_o(ovf_a), .underflow_o(udf_a)
  );

  vc_circular_buffer #(.NUM_VC(B_VC), .BUFFER_SIZE(B_BS), .FLIT_SIZE(8)) u_dut_b (
    .clk(clk), .rst(rst), .data_i(data_b), .write_i(write_b), .write_vc_i(wvc_b),
    .read_i(read_b), .read_vc_i(rvc_b), .data_o(dout_b), .is_full_o(full_b),
    .is_empty_o(empty_b), .count_o(count_b), .credit_o(credit_b), .credit_vc_o(cvc_b),
    .overflow_o(ovf_b), .underflow_o(udf_b)
  );

  // reference model: one flit queue per (instance, VC)
  logic [7:0] exp_q [2][4][$];
  int         cap [2];
  int         nvc [2];
  logic       e_ovf [2];
  logic       e_udf [2];
  logic       e_cred [2];
  int         e_cvc [2];
  logic [7:0] obs_head [2];
  logic [7:0] exp_head [2];
  bit         hv [2];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 4; v++) exp_q[s][v].delete();
      e_ovf[s] = 1'b0; e_udf[s] = 1'b0; e_cred[s] = 1'b0; e_cvc[s] = 0;
    end
  endtask

  task automatic model_step(input int s, input bit w, input int wvc, input logic [7:0] d,
                            input bit r, input int rvc);
    bit rd_ok, wr_ok;
    rd_ok = r && (rvc < nvc[s]) && (exp_q[s][rvc].size() > 0);
    wr_ok = w && (wvc < nvc[s]) && ((exp_q[s][wvc].size() < cap[s]) || (rd_ok && rvc == wvc));
    if (rd_ok) void'(exp_q[s][rvc].pop_front());
    if (wr_ok) exp_q[s][wvc].push_back(d);
    e_cred[s] = rd_ok;
    if (rd_ok) e_cvc[s] = rvc;
    if (w && !wr_ok) e_ovf[s] = 1'b1;
    if (r && !rd_ok) e_udf[s] = 1'b1;
  endtask

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic cyc_a(input bit w, input int wvc, input logic [7:0] d, input bit r, input int rvc);
    write_a = w; wvc_a = wvc[A_VW-1:0]; data_a = d; read_a = r; rvc_a = rvc[A_VW-1:0];
    #1;
    obs_head[0] = dout_a;
    hv[0] = r && (rvc < A_VC) && (exp_q[0][rvc].size() > 0);
    if (hv[0]) exp_head[0] = exp_q[0][rvc][0];
    @(posedge clk);
    model_step(0, w, wvc, d, r, rvc);
    @(negedge clk);
    write_a = 1'b0; read_a = 1'b0;
  endtask

  task automatic cyc_b(input bit w, input int wvc, input logic [7:0] d, input bit r, input int rvc);
    write_b = w; wvc_b = wvc[B_VW-1:0]; data_b = d; read_b = r; rvc_b = rvc[B_VW-1:0];
    #1;
    obs_head[1] = dout_b;
    hv[1] = r && (rvc < B_VC) && (exp_q[1][rvc].size() > 0);
    if (hv[1]) exp_head[1] = exp_q[1][rvc][0];
    @(posedge clk);
    model_step(1, w, wvc, d, r, rvc);
    @(negedge clk);
    write_b = 1'b0; read_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (empty_a !== 2'b11) begin n_bad++; $display("FAIL reset_empty_a: got %b exp 11", empty_a); end
    n_cmp++; if (full_a !== 2'b00) begin n_bad++; $display("FAIL reset_full_a: got %b exp 00", full_a); end
    n_cmp++; if (count_a !== '0) begin n_bad++; $display("FAIL reset_count_a: got %h exp 0", count_a); end
    n_cmp++; if (credit_a !== 1'b0) begin n_bad++; $display("FAIL reset_credit_a: got %b exp 0", credit_a); end
    n_cmp++; if (cvc_a !== '0) begin n_bad++; $display("FAIL reset_credit_vc_a: got %h exp 0", cvc_a); end
    n_cmp++; if ({ovf_a, udf_a} !== 2'b00) begin n_bad++; $display("FAIL reset_err_a: got %b exp 00", {ovf_a, udf_a}); end
    n_cmp++; if (empty_b !== 3'b111) begin n_bad++; $display("FAIL reset_empty_b: got %b exp 111", empty_b); end
    n_cmp++; if (count_b !== '0) begin n_bad++; $display("FAIL reset_count_b: got %h exp 0", count_b); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b1, 0, 8'(8'h11 + i), 1'b0, 0);
      n_cmp++; if (count_a[3:0] !== 4'(i + 1)) begin n_bad++; $display("FAIL fill_count0[%0d]: got %0d exp %0d", i, count_a[3:0], i + 1); end
    end
    cyc_a(1'b1, 0, 8'h19, 1'b0, 0);
    n_cmp++; if (full_a[0] !== 1'b1) begin n_bad++; $display("FAIL fill_full0: got %b exp 1", full_a[0]); end
    n_cmp++; if (count_a[3:0] !== 4'd8) begin n_bad++; $display("FAIL fill_count0_after_9th: got %0d exp 8", count_a[3:0]); end
    n_cmp++; if (ovf_a !== 1'b1) begin n_bad++; $display("FAIL fill_overflow: got %b exp 1", ovf_a); end
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b0, 0, 8'h00, 1'b1, 0);
      n_cmp++; if (obs_head[0] !== 8'(8'h11 + i)) begin n_bad++; $display("FAIL drain_data[%0d]: got %h exp %h", i, obs_head[0], 8'(8'h11 + i)); end
      n_cmp++; if ({credit_a, cvc_a} !== 2'b10) begin n_bad++; $display("FAIL drain_credit[%0d]: got %b%b exp 10", i, credit_a, cvc_a); end
    end
    n_cmp++; if (empty_a[0] !== 1'b1) begin n_bad++; $display("FAIL drain_empty0: got %b exp 1", empty_a[0]); end
    n_cmp++; if (udf_a !== 1'b0) begin n_bad++; $display("FAIL drain_no_underflow: got %b exp 0", udf_a); end
    cyc_a(1'b0, 0, 8'h00, 1'b1, 0);
    n_cmp++; if (credit_a !== 1'b0) begin n_bad++; $display("FAIL empty_read_credit: got %b exp 0", credit_a); end
    n_cmp++; if (udf_a !== 1'b1) begin n_bad++; $display("FAIL empty_read_underflow: got %b exp 1", udf_a); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_l [5];
    exp_l = '{8'h23, 8'h24, 8'h30, 8'h31, 8'h32};
    do_reset();
    for (int i = 0; i < 5; i++) cyc_b(1'b1, 2, 8'(8'h20 + i), 1'b0, 0);
    n_cmp++; if (count_b[8:6] !== 3'd5) begin n_bad++; $display("FAIL wrap_count_5: got %0d exp 5", count_b[8:6]); end
    n_cmp++; if (full_b !== 3'b100) begin n_bad++; $display("FAIL wrap_full: got %b exp 100", full_b); end
    for (int i = 0; i < 3; i++) begin
      cyc_b(1'b0, 0, 8'h00, 1'b1, 2);
      n_cmp++; if (obs_head[1] !== 8'(8'h20 + i)) begin n_bad++; $display("FAIL wrap_read1[%0d]: got %h exp %h", i, obs_head[1], 8'(8'h20 + i)); end
    end
    n_cmp++; if (count_b[8:6] !== 3'd2) begin n_bad++; $display("FAIL wrap_count_2: got %0d exp 2", count_b[8:6]); end
    for (int i = 0; i < 3; i++) cyc_b(1'b1, 2, 8'(8'h30 + i), 1'b0, 0);
    n_cmp++; if (count_b[8:6] !== 3'd5) begin n_bad++; $display("FAIL wrap_count_back_5: got %0d exp 5", count_b[8:6]); end
    for (int i = 0; i < 5; i++) begin
      cyc_b(1'b0, 0, 8'h00, 1'b1, 2);
      n_cmp++; if (obs_head[1] !== exp_l[i]) begin n_bad++; $display("FAIL wrap_read2[%0d]: got %h exp %h", i, obs_head[1], exp_l[i]); end
      n_cmp++; if ({credit_b, cvc_b} !== 3'b110) begin n_bad++; $display("FAIL wrap_credit[%0d]: got %b%b exp 110", i, credit_b, cvc_b); end
    end
    n_cmp++; if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL wrap_no_overflow: got %b exp 0", ovf_b); end
    cyc_b(1'b1, 3, 8'h77, 1'b0, 0);
    n_cmp++; if ({ovf_b, count_b} !== {1'b1, 9'd0}) begin n_bad++; $display("FAIL invalid_vc_write: got ovf=%b cnt=%h exp ovf=1 cnt=0", ovf_b, count_b); end
    cyc_b(1'b0, 0, 8'h00, 1'b1, 3);
    n_cmp++; if ({udf_b, credit_b} !== 2'b10) begin n_bad++; $display("FAIL invalid_vc_read: got udf/credit=%b%b exp 10", udf_b, credit_b); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    cyc_a(1'b1, 0, 8'h55, 1'b0, 0);
    cyc_a(1'b1, 1, 8'hAA, 1'b1, 0);
    n_cmp++; if (obs_head[0] !== 8'h55) begin n_bad++; $display("FAIL same_cycle_data: got %h exp 55", obs_head[0]); end
    n_cmp++; if (count_a !== {4'd1, 4'd0}) begin n_bad++; $display("FAIL same_cycle_counts: got %h exp 10", count_a); end
    n_cmp++; if ({credit_a, cvc_a} !== 2'b10) begin n_bad++; $display("FAIL same_cycle_credit: got %b%b exp 10", credit_a, cvc_a); end
    cyc_a(1'b0, 0, 8'h00, 1'b1, 1);
    n_cmp++; if (obs_head[0] !== 8'hAA) begin n_bad++; $display("FAIL same_cycle_vc1_data: got %h exp aa", obs_head[0]); end
    n_cmp++; if ({credit_a, cvc_a} !== 2'b11) begin n_bad++; $display("FAIL same_cycle_vc1_credit: got %b%b exp 11", credit_a, cvc_a); end
  endtask

  task automatic test_full_empty_rw();
    do_reset();
    for (int i = 0; i < 8; i++) cyc_a(1'b1, 0, 8'($urandom_range(0, 255)), 1'b0, 0);
    cyc_a(1'b1, 0, 8'hC3, 1'b1, 0);
    n_cmp++; if (obs_head[0] !== exp_head[0]) begin n_bad++; $display("FAIL full_rw_data: got %h exp %h", obs_head[0], exp_head[0]); end
    n_cmp++; if (count_a[3:0] !== 4'd8) begin n_bad++; $display("FAIL full_rw_count: got %0d exp 8", count_a[3:0]); end
    n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL full_rw_overflow: got %b exp 0", ovf_a); end
    n_cmp++; if (credit_a !== 1'b1) begin n_bad++; $display("FAIL full_rw_credit: got %b exp 1", credit_a); end
    cyc_a(1'b1, 1, 8'h5A, 1'b1, 1);
    n_cmp++; if (count_a[7:4] !== 4'd1) begin n_bad++; $display("FAIL empty_rw_count: got %0d exp 1", count_a[7:4]); end
    n_cmp++; if ({udf_a, credit_a} !== 2'b10) begin n_bad++; $display("FAIL empty_rw_udf_credit: got %b%b exp 10", udf_a, credit_a); end
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b0, 0, 8'h00, 1'b1, 0);
      n_cmp++; if (obs_head[0] !== exp_head[0]) begin n_bad++; $display("FAIL full_rw_drain[%0d]: got %h exp %h", i, obs_head[0], exp_head[0]); end
    end
    n_cmp++; if (obs_head[0] !== 8'hC3) begin n_bad++; $display("FAIL full_rw_last: got %h exp c3", obs_head[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 0, 8'(8'h40 + i), 1'b0, 0);
    cyc_a(1'b0, 0, 8'h00, 1'b1, 0);
    n_cmp++; if (credit_a !== 1'b1) begin n_bad++; $display("FAIL pre_rst_credit: got %b exp 1", credit_a); end
    read_a = 1'b1; rvc_a = '0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; read_a = 1'b0;
    model_reset();
    n_cmp++; if (credit_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_credit: got %b exp 0", credit_a); end
    n_cmp++; if (count_a !== '0) begin n_bad++; $display("FAIL rst_mid_count: got %h exp 0", count_a); end
    n_cmp++; if ({empty_a, full_a} !== 4'b1100) begin n_bad++; $display("FAIL rst_mid_flags: got %b exp 1100", {empty_a, full_a}); end
    n_cmp++; if ({ovf_a, udf_a} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_err: got %b exp 00", {ovf_a, udf_a}); end
    @(negedge clk);
    n_cmp++; if (credit_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_credit_late: got %b exp 0", credit_a); end
  endtask

  task automatic test_random();
    bit w, r;
    int wvc, rvc;
    do_reset();
    for (int i = 0; i < 250; i++) begin
      w = ($urandom_range(0, 99) < 60); r = ($urandom_range(0, 99) < 50);
      wvc = $urandom_range(0, A_VC - 1); rvc = $urandom_range(0, A_VC - 1);
      cyc_a(w, wvc, 8'($urandom_range(0, 255)), r, rvc);
      if (hv[0]) begin
        n_cmp++; if (obs_head[0] !== exp_head[0]) begin n_bad++; $display("FAIL rand_a_data[%0d]: got %h exp %h", i, obs_head[0], exp_head[0]); end
      end
      for (int v = 0; v < A_VC; v++) begin
        n_cmp++; if (count_a[v*A_CW +: A_CW] !== A_CW'(exp_q[0][v].size())) begin n_bad++; $display("FAIL rand_a_count[%0d] vc%0d: got %0d exp %0d", i, v, count_a[v*A_CW +: A_CW], exp_q[0][v].size()); end
        n_cmp++; if ({full_a[v], empty_a[v]} !== {exp_q[0][v].size() == A_BS, exp_q[0][v].size() == 0}) begin n_bad++; $display("FAIL rand_a_flags[%0d] vc%0d: got %b%b", i, v, full_a[v], empty_a[v]); end
      end
      n_cmp++; if ({credit_a, ovf_a, udf_a} !== {e_cred[0], e_ovf[0], e_udf[0]}) begin n_bad++; $display("FAIL rand_a_status[%0d]: got %b%b%b exp %b%b%b", i, credit_a, ovf_a, udf_a, e_cred[0], e_ovf[0], e_udf[0]); end
      if (e_cred[0]) begin
        n_cmp++; if (cvc_a !== A_VW'(e_cvc[0])) begin n_bad++; $display("FAIL rand_a_cvc[%0d]: got %0d exp %0d", i, cvc_a, e_cvc[0]); end
      end
    end
    for (int i = 0; i < 250; i++) begin
      w = ($urandom_range(0, 99) < 60); r = ($urandom_range(0, 99) < 50);
      wvc = $urandom_range(0, 3); rvc = $urandom_range(0, 3);
      cyc_b(w, wvc, 8'($urandom_range(0, 255)), r, rvc);
      if (hv[1]) begin
        n_cmp++; if (obs_head[1] !== exp_head[1]) begin n_bad++; $display("FAIL rand_b_data[%0d]: got %h exp %h", i, obs_head[1], exp_head[1]); end
      end
      for (int v = 0; v < B_VC; v++) begin
        n_cmp++; if (count_b[v*B_CW +: B_CW] !== B_CW'(exp_q[1][v].size())) begin n_bad++; $display("FAIL rand_b_count[%0d] vc%0d: got %0d exp %0d", i, v, count_b[v*B_CW +: B_CW], exp_q[1][v].size()); end
        n_cmp++; if ({full_b[v], empty_b[v]} !== {exp_q[1][v].size() == B_BS, exp_q[1][v].size() == 0}) begin n_bad++; $display("FAIL rand_b_flags[%0d] vc%0d: got %b%b", i, v, full_b[v], empty_b[v]); end
      end
      n_cmp++; if ({credit_b, ovf_b, udf_b} !== {e_cred[1], e_ovf[1], e_udf[1]}) begin n_bad++; $display("FAIL rand_b_status[%0d]: got %b%b%b exp %b%b%b", i, credit_b, ovf_b, udf_b, e_cred[1], e_ovf[1], e_udf[1]); end
      if (e_cred[1]) begin
        n_cmp++; if (cvc_b !== B_VW'(e_cvc[1])) begin n_bad++; $display("FAIL rand_b_cvc[%0d]: got %0d exp %0d", i, cvc_b, e_cvc[1]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    data_a = '0; write_a = 1'b0; wvc_a = '0; read_a = 1'b0; rvc_a = '0;
    data_b = '0; write_b = 1'b0; wvc_b = '0; read_b = 1'b0; rvc_b = '0;
    cap[0] = A_BS; nvc[0] = A_VC;
    cap[1] = B_BS; nvc[1] = B_VC;
    model_reset();
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_same_cycle();
    test_full_empty_rw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
